// File: rtl/alu_exec_seq.sv
// Sequential execute unit: AND/ORR/ADD/SUB/PASS_B in one cycle, LSL/LSR one bit per cycle, NZCV flags.
// Latency: 1 cycle for single-cycle ops and zero shifts, N+1 cycles for a shift by N.
// Backpressure: result/flags held in DONE until out_ready; in_ready low while SHIFT or DONE.
module alu_exec_seq #(
   parameter int WIDTH   = 64,
   parameter int SHAMT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alu_control,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               flag_n,
   output logic               flag_z,
   output logic               flag_c,
   output logic               flag_v
);

   localparam logic [3:0] ALU_AND    = 4'b0000;
   localparam logic [3:0] ALU_ORR    = 4'b0001;
   localparam logic [3:0] ALU_ADD    = 4'b0010;
   localparam logic [3:0] ALU_LSL    = 4'b0011;
   localparam logic [3:0] ALU_LSR    = 4'b0100;
   localparam logic [3:0] ALU_SUB    = 4'b0110;
   localparam logic [3:0] ALU_PASS_B = 4'b0111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   sh_reg;
   logic [SHAMT_W-1:0] sh_cnt;
   logic               shift_left;

   logic               op_sub;
   logic               is_shift;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   res_calc;
   logic               c_calc;
   logic               v_calc;
   logic [WIDTH-1:0]   shift_nxt;

   // Single-cycle result and flags straight from the request inputs; SUB reuses the adder as a + ~b + 1.
   always_comb begin
      op_sub   = (alu_control == ALU_SUB);
      is_shift = (alu_control == ALU_LSL) || (alu_control == ALU_LSR);
      b_eff    = op_sub ? ~b : b;
      sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sub};
      res_calc = '0;
      c_calc   = 1'b0;
      v_calc   = 1'b0;
      case (alu_control)
         ALU_AND:    res_calc = a & b;
         ALU_ORR:    res_calc = a | b;
         ALU_ADD,
         ALU_SUB: begin
            res_calc = sum[WIDTH-1:0];
            c_calc   = sum[WIDTH];
            v_calc   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_PASS_B: res_calc = b;
         ALU_LSL,
         ALU_LSR:    res_calc = a;  // only reached with shamt == 0
         default:    res_calc = '0;
      endcase
   end

   // One-bit step of the iterative shifter, zero-filling in both directions.
   always_comb begin
      shift_nxt = shift_left ? {sh_reg[WIDTH-2:0], 1'b0} : {1'b0, sh_reg[WIDTH-1:1]};
   end

   // Control FSM with registered handshake, result and flag outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         result     <= '0;
         flag_n     <= 1'b0;
         flag_z     <= 1'b0;
         flag_c     <= 1'b0;
         flag_v     <= 1'b0;
         sh_reg     <= '0;
         sh_cnt     <= '0;
         shift_left <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (is_shift && (shamt != '0)) begin
                     sh_reg     <= a;
                     sh_cnt     <= shamt;
                     shift_left <= (alu_control == ALU_LSL);
                     state      <= ST_SHIFT;
                  end else begin
                     result    <= res_calc;
                     flag_n    <= res_calc[WIDTH-1];
                     flag_z    <= (res_calc == '0);
                     flag_c    <= c_calc;
                     flag_v    <= v_calc;
                     out_valid <= 1'b1;
                     state     <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               sh_reg <= shift_nxt;
               sh_cnt <= sh_cnt - SHAMT_W'(1);
               // Last step: the value shifted this cycle is the final result.
               if (sh_cnt == SHAMT_W'(1)) begin
                  result    <= shift_nxt;
                  flag_n    <= shift_nxt[WIDTH-1];
                  flag_z    <= (shift_nxt == '0);
                  flag_c    <= 1'b0;
                  flag_v    <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for alu_exec_seq: directed vectors, expected responses queued at issue time.
// A monitor pops and compares on every output handshake; latency and handshake checks run inline.
// Result is held under backpressure; reset aborts an in-flight shift.
module tb_alu_exec_seq;

   localparam logic [3:0] ALU_AND    = 4'b0000;
   localparam logic [3:0] ALU_ORR    = 4'b0001;
   localparam logic [3:0] ALU_ADD    = 4'b0010;
   localparam logic [3:0] ALU_LSL    = 4'b0011;
   localparam logic [3:0] ALU_LSR    = 4'b0100;
   localparam logic [3:0] ALU_SUB    = 4'b0110;
   localparam logic [3:0] ALU_PASS_B = 4'b0111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_control;
   logic [63:0] a;
   logic [63:0] b;
   logic [5:0]  shamt;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        flag_n;
   logic        flag_z;
   logic        flag_c;
   logic        flag_v;

   typedef struct {
      string       name;
      logic [63:0] res;
      logic [3:0]  nzcv;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_exec_seq #(.WIDTH(64), .SHAMT_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .a           (a),
      .b           (b),
      .shamt       (shamt),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .flag_n      (flag_n),
      .flag_z      (flag_z),
      .flag_c      (flag_c),
      .flag_v      (flag_v)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input string nm, input logic [63:0] r, input logic [3:0] f);
      exp_t e;
      e.name = nm;
      e.res  = r;
      e.nzcv = f;
      return e;
   endfunction

   // Issue one request; caller is positioned #1 after a rising edge. Returns #1 after the accept edge.
   task automatic send(input logic [3:0] code, input logic [63:0] av, input logic [63:0] bv,
                       input logic [5:0] sh, input bit push, input exp_t e);
      int w = 0;
      while (!in_ready && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      check({e.name, "_in_ready_at_issue"}, 64'(in_ready), 64'd1);
      alu_control = code;
      a           = av;
      b           = bv;
      shamt       = sh;
      in_valid    = 1'b1;
      if (push) exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid    = 1'b0;
      a           = 64'hDEAD_BEEF_DEAD_BEEF;
      b           = 64'hDEAD_BEEF_DEAD_BEEF;
   endtask

   // Count cycles from the accept edge until out_valid; in_ready must stay low the whole time.
   task automatic wait_valid(input int exp_lat, input string name);
      int lat     = 1;
      bit bad_rdy = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) bad_rdy = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_in_ready_busy"}, 64'(bad_rdy | in_ready), 64'd0);
   endtask

   // Single op with out_ready high: issue, check latency, let the handshake complete.
   task automatic run_op(input logic [3:0] code, input logic [63:0] av, input logic [63:0] bv,
                         input logic [5:0] sh, input int lat, input exp_t e);
      send(code, av, bv, sh, 1'b1, e);
      wait_valid(lat, e.name);
      @(posedge clk); #1;
   endtask

   // Scoreboard monitor: compare on every output handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got result %h, expected no output", result);
            end else begin
               e = exp_q.pop_front();
               check({e.name, "_result"}, result, e.res);
               check({e.name, "_nzcv"}, 64'({flag_n, flag_z, flag_c, flag_v}), 64'(e.nzcv));
            end
         end
      end
   end

   initial begin
      bit seen;
      exp_t dummy;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      alu_control = 4'b0;
      a           = '0;
      b           = '0;
      shamt       = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_result", result, 64'd0);
      check("reset_flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1,
             mk("add_ovf", 64'h8000_0000_0000_0000, 4'b1001));
      run_op(ALU_SUB, 64'h1234, 64'h1234, 6'd0, 1,
             mk("sub_eq", 64'd0, 4'b0110));
      run_op(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1,
             mk("add_carry", 64'd0, 4'b0110));
      run_op(ALU_SUB, 64'd0, 64'd1, 6'd0, 1,
             mk("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000));
      run_op(ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 6'd0, 1,
             mk("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011));
      run_op(ALU_AND, 64'hF0F0, 64'hFF00, 6'd0, 1,
             mk("and", 64'hF000, 4'b0000));
      run_op(ALU_ORR, 64'hF0F0, 64'h0F0F, 6'd0, 1,
             mk("orr", 64'hFFFF, 4'b0000));
      run_op(ALU_PASS_B, 64'h5555, 64'hABCD, 6'd0, 1,
             mk("pass_b", 64'hABCD, 4'b0000));

      // Reset in the middle of a long shift: outputs clear at once and the shift never completes.
      dummy = mk("lsl40_abort", 64'd0, 4'b0000);
      send(ALU_LSL, 64'd1, 64'd0, 6'd40, 1'b0, dummy);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_result", result, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (60) begin
         @(posedge clk); #1;
         seen = seen | out_valid;
      end
      check("abort_no_output", 64'(seen), 64'd0);

      run_op(ALU_LSL, 64'd1, 64'd0, 6'd63, 64,
             mk("lsl63", 64'h8000_0000_0000_0000, 4'b1000));
      run_op(ALU_LSR, 64'h8000_0000_0000_0000, 64'd0, 6'd1, 2,
             mk("lsr1", 64'h4000_0000_0000_0000, 4'b0000));

      // Stall the consumer: result must hold and a competing request must be ignored.
      out_ready = 1'b0;
      send(ALU_LSR, 64'hF000_0000_0000_0000, 64'd0, 6'd4, 1'b1,
           mk("lsr4_stall", 64'h0F00_0000_0000_0000, 4'b0000));
      wait_valid(5, "lsr4_stall");
      in_valid    = 1'b1;
      alu_control = ALU_ADD;
      a           = 64'd1;
      b           = 64'd2;
      repeat (5) begin
         check("stall_result", result, 64'h0F00_0000_0000_0000);
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("post_hs_out_valid", 64'(out_valid), 64'd0);
      check("post_hs_in_ready", 64'(in_ready), 64'd1);

      run_op(4'b1111, 64'h1234, 64'h5678, 6'd0, 1,
             mk("unknown", 64'd0, 4'b0100));
      run_op(ALU_LSR, 64'h1234_5678_9ABC_DEF0, 64'd0, 6'd0, 1,
             mk("lsr0", 64'h1234_5678_9ABC_DEF0, 4'b0000));

      repeat (10) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global guard against a stuck run.
   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Sequential 64-bit execute unit that consumes the 4-bit ALU control code emitted by the execute-stage ALU control decode, together with operands A/B and a shift amount.
- Single-cycle ops (AND, ORR, ADD, SUB, PASS_B) complete in one cycle; LSL/LSR iterate one bit per cycle.
- Valid/ready handshakes on both sides let it serve as the multi-cycle ALU for the multicycle datapath.
- Produces the result plus NZCV flags for CBZ/CBNZ/B.cond.

Parameters:
WIDTH, 64, datapath width in bits (must be a power of two, at least 8).
SHAMT_W, 6, shift-amount width, equal to log2(WIDTH).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request carries a valid operation
in_ready  output  1  unit can accept a request this cycle
alu_control  input  4  operation code (`constants.vh` ALU_* codes)
a  input  WIDTH  operand A (Rn)
b  input  WIDTH  operand B (Rm, immediate or address offset)
shamt  input  SHAMT_W  shift amount for LSL/LSR
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts the result
result  output  WIDTH  operation result
flag_n  output  1  result[WIDTH-1]
flag_z  output  1  result equals zero
flag_c  output  1  carry out (ADD) / not-borrow (SUB)
flag_v  output  1  signed overflow (ADD/SUB)

Behaviour:
- Codes, fixed in `constants.vh`:
  - ALU_AND 0000, ALU_ORR 0001, ALU_ADD 0010, ALU_SUB 0110, ALU_PASS_B 0111, ALU_LSL 0011, ALU_LSR 0100.
  - Any other code: result 0, all flags 0, single-cycle.
- Reset (rst_n low, asynchronous): state IDLE, in_ready 1, out_valid 0, result 0, all flags 0, shift counter 0.
  - Reset asserted mid-shift or while holding an output aborts the operation; the result is discarded.
- FSM has three states:
  - IDLE: in_ready=1. On in_valid, capture the operands and code.
    - Single-cycle code or shamt=0: compute and go to DONE.
    - LSL/LSR with shamt>0: load the shift register with a, load the counter with shamt, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle, shift the register by 1 (LSL: shift left and zero-fill; LSR: logical shift right and zero-fill) and decrement the counter. When the counter reaches 1, this cycle's shifted value is final; go to DONE.
  - DONE: out_valid=1, in_ready=0. Result and flags are held stable until out_ready. On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency, measured from the accept edge T:
  - Single-cycle op, or shift with shamt=0 (result = a): out_valid is high starting the cycle after T.
  - Shift with shamt=N>0: out_valid is high starting N+1 cycles after T.
  - The shifted value is fully computed by the state machine before out_valid rises.
- No request is accepted while the unit is in SHIFT or DONE. The unit returns to IDLE one cycle after the out_ready handshake, so throughput is at most one operation per 2 cycles.
- Arithmetic:
  - ADD: {c, result} = a + b.
  - SUB: {c, result} = a + ~b + 1, so c=1 means no borrow.
  - V = (a[msb] == b'[msb]) && (result[msb] != a[msb]), where b' is b for ADD and ~b for SUB.
  - AND, ORR, PASS_B, LSL, LSR: c=0, v=0. n and z always reflect the result.
- Flags are registered together with result and are valid only while out_valid=1.
- in_valid together with an unknown code is not an error; the unit returns zero.
- Shift amounts of WIDTH-1 are legal. Operand inputs are ignored outside the IDLE accept cycle.

Test Plan:
- Reset: drive rst_n low mid-SHIFT (LSL, shamt=40, at cycle 10). Required: out_valid=0, in_ready=1, result=0 immediately; no out_valid after rst_n release.
- ADD overflow: a=0x7FFFFFFFFFFFFFFF, b=1. Required: one cycle later out_valid=1, result=0x8000000000000000, N=1 Z=0 C=0 V=1.
- SUB equal: a=b=0x1234. Required: result=0, Z=1, C=1, V=0, N=0.
- LSL: a=1, shamt=63, out_ready held 1. Required: out_valid rises exactly 64 cycles after accept, result=0x8000000000000000, N=1; in_ready=0 throughout.
- LSR zero-fill and backpressure: a=0xF000000000000000, shamt=4, out_ready=0 for 5 cycles. Required: result=0x0F00000000000000 stable across the stall; in_ready stays 0; a new in_valid is ignored until the return to IDLE.
- Corner codes: PASS_B with b=0xABCD gives result 0xABCD, C=V=0. Unknown code 1111 gives result 0, Z=1. LSR with shamt=0 returns a after one cycle.
